// File: rtl/mist_sector_client_if.sv
// HPS block-device bundle (hps_io sd_* side): request, ack, mount and sector-buffer port.
interface mist_sector_client_if #(
  parameter int unsigned NDRV = 4
);
  logic [NDRV-1:0] mist_mounted;
  logic [63:0]     mist_imgsize;
  logic [31:0]     mist_lba;
  logic [NDRV-1:0] mist_rd;
  logic [NDRV-1:0] mist_wr;
  logic [NDRV-1:0] mist_ack;
  logic [8:0]      mist_buffaddr;
  logic [7:0]      mist_buffdout;
  logic [7:0]      mist_buffdin;
  logic            mist_buffwr;

  modport master (
    input  mist_mounted, mist_imgsize, mist_ack, mist_buffaddr, mist_buffdout, mist_buffwr,
    output mist_lba, mist_rd, mist_wr, mist_buffdin
  );

  modport slave (
    output mist_mounted, mist_imgsize, mist_ack, mist_buffaddr, mist_buffdout, mist_buffwr,
    input  mist_lba, mist_rd, mist_wr, mist_buffdin
  );
endinterface

// File: rtl/mist_sector_client.sv
// Single-sector read/write initiator towards the MiSTer HPS block device, with a
// 512-byte dual-port sector buffer, per-drive mount tracking and an ack timeout.
module mist_sector_client #(
  parameter int unsigned TMO_W = 24,
  parameter int unsigned NDRV  = 4
) (
  input  logic                 clk21m,
  input  logic                 rstn,
  input  logic                 req_rd,
  input  logic                 req_wr,
  input  logic [1:0]           req_drv,
  input  logic [31:0]          req_lba,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic [8:0]           buf_addr,
  input  logic [7:0]           buf_wdat,
  input  logic                 buf_we,
  output logic [7:0]           buf_rdat,
  output logic [NDRV-1:0]      mounted,
  mist_sector_client_if.master hps
);

  localparam int unsigned AW        = 9;
  localparam int unsigned DW        = 8;
  localparam int unsigned BUF_DEPTH = 512;
  localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);

  typedef enum logic [2:0] {IDLE, REQ, XFER, DONE, FAIL} state_t;

  state_t            state_q, state_d;
  logic              busy_d, done_d, err_d;
  logic [NDRV-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [31:0]       lba_q, lba_d;
  logic [1:0]        drv_q, drv_d;
  logic              op_rd_q, op_rd_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DW-1:0]     buffdin_q;
  logic [DW-1:0]     mem [BUF_DEPTH];
  logic              we_a, we_b;

  // State, control and output registers
  always_ff @(posedge clk21m or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      lba_q   <= '0;
      drv_q   <= '0;
      op_rd_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      lba_q   <= lba_d;
      drv_q   <= drv_d;
      op_rd_q <= op_rd_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    lba_d   = lba_q;
    drv_d   = drv_q;
    op_rd_d = op_rd_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (req_rd || req_wr) begin
          busy_d  = 1'b1;
          drv_d   = req_drv;
          op_rd_d = req_rd;
          lba_d   = req_lba;
          tmo_d   = '0;
          if (mounted[req_drv]) begin
            state_d = REQ;
            if (req_rd) rd_d = NDRV'(1) << req_drv;
            else        wr_d = NDRV'(1) << req_drv;
          end else begin
            state_d = FAIL;
          end
        end
      end
      REQ: begin
        if (hps.mist_mounted[drv_q] || (!hps.mist_ack[drv_q] && tmo_q == TMO_LAST)) begin
          rd_d    = '0;
          wr_d    = '0;
          state_d = FAIL;
        end else if (hps.mist_ack[drv_q]) begin
          rd_d    = '0;
          wr_d    = '0;
          state_d = XFER;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      XFER: begin
        // A remount of the active drive invalidates whatever is being transferred
        if (hps.mist_mounted[drv_q]) begin
          state_d = FAIL;
        end else if (!hps.mist_ack[drv_q]) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      FAIL: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Mount state follows img_mounted pulses; an empty image means unmounted
  always_ff @(posedge clk21m or negedge rstn) begin
    if (!rstn) begin
      mounted <= '0;
    end else begin
      for (int unsigned n = 0; n < NDRV; n++) begin
        if (hps.mist_mounted[n]) mounted[n] <= (hps.mist_imgsize != 64'd0);
      end
    end
  end

  assign we_a = buf_we && !busy;
  assign we_b = hps.mist_buffwr && (state_q == XFER) && op_rd_q;

  // Sector buffer storage, no reset
  always_ff @(posedge clk21m) begin
    if (we_a) mem[buf_addr] <= buf_wdat;
    if (we_b) mem[hps.mist_buffaddr] <= hps.mist_buffdout;
  end

  // Registered read ports, one cycle after the address
  always_ff @(posedge clk21m or negedge rstn) begin
    if (!rstn) begin
      buf_rdat  <= '0;
      buffdin_q <= '0;
    end else begin
      buf_rdat  <= mem[AW'(buf_addr)];
      buffdin_q <= mem[AW'(hps.mist_buffaddr)];
    end
  end

  assign hps.mist_lba     = lba_q;
  assign hps.mist_rd      = rd_q;
  assign hps.mist_wr      = wr_q;
  assign hps.mist_buffdin = buffdin_q;

endmodule

// File: tb/tb_mist_sector_client.sv
// Self-checking bench for mist_sector_client: request table plus hand-written abort,
// timeout and contention sequences, with a queue scoreboard for buffer data.
module tb_mist_sector_client;

  logic        clk21m = 1'b0;
  logic        rstn;
  logic        req_rd, req_wr;
  logic [1:0]  req_drv;
  logic [31:0] req_lba;
  logic        busy, done, err;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_wdat;
  logic        buf_we;
  logic [7:0]  buf_rdat;
  logic [3:0]  mounted;

  mist_sector_client_if #(.NDRV(4)) hps ();

  mist_sector_client #(.TMO_W(4), .NDRV(4)) dut (
    .clk21m   (clk21m),
    .rstn     (rstn),
    .req_rd   (req_rd),
    .req_wr   (req_wr),
    .req_drv  (req_drv),
    .req_lba  (req_lba),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .buf_addr (buf_addr),
    .buf_wdat (buf_wdat),
    .buf_we   (buf_we),
    .buf_rdat (buf_rdat),
    .mounted  (mounted),
    .hps      (hps)
  );

  always #5 clk21m = ~clk21m;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  drv;
    logic [31:0] lba;
    logic [3:0]  exp_rd;
    logic [3:0]  exp_wr;
    logic        exp_ok;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] sb[$];
  vec_t       vecs[5];

  always @(negedge clk21m) begin
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk21m);
    #1;
  endtask

  task automatic mount(input int drv, input logic [63:0] size);
    hps.mist_imgsize = size;
    hps.mist_mounted = 4'b0001 << drv;
    tick();
    hps.mist_mounted = '0;
  endtask

  // Wait (bounded) for done or err; returns cycles waited, 0 if the bound expired
  task automatic wait_end(input string name, input int max, output int cyc);
    cyc = 0;
    for (int c = 1; c <= max; c++) begin
      tick();
      if (done || err) begin
        cyc = c;
        break;
      end
    end
    if (cyc == 0) check({name, "_bound"}, 64'd0, 64'd1);
  endtask

  task automatic run_req(input vec_t v);
    int d0, e0;
    logic [7:0] exp;
    d0 = done_cnt;
    e0 = err_cnt;
    req_rd = v.rd; req_wr = v.wr; req_drv = v.drv; req_lba = v.lba;
    tick();
    req_rd = 1'b0; req_wr = 1'b0;
    check("busy_rise", busy, 1);
    check("mist_rd", hps.mist_rd, v.exp_rd);
    check("mist_wr", hps.mist_wr, v.exp_wr);
    check("mist_lba", hps.mist_lba, v.lba);
    if (!v.exp_ok) begin
      tick();
      check("fail_err", err, 1);
      check("fail_busy", busy, 0);
      check("fail_no_req", hps.mist_rd | hps.mist_wr, 0);
      tick();
      check("err_pulse", err, 0);
    end else begin
      tick(); tick();
      check("req_held", hps.mist_rd | hps.mist_wr, v.exp_rd | v.exp_wr);
      hps.mist_ack = 4'b0001 << v.drv;
      tick();
      check("req_drop", {hps.mist_rd, hps.mist_wr}, 0);
      check("busy_xfer", busy, 1);
      for (int i = 0; i < 512; i++) begin
        hps.mist_buffaddr = 9'(i);
        if (v.exp_rd != 4'd0) begin
          hps.mist_buffwr  = 1'b1;
          hps.mist_buffdout = 8'(i) ^ 8'hA5;
        end else begin
          sb.push_back(8'(i));
        end
        tick();
        if (v.exp_rd == 4'd0) begin
          exp = sb.pop_front();
          check("buffdin", hps.mist_buffdin, exp);
        end
      end
      hps.mist_buffwr = 1'b0;
      hps.mist_ack    = '0;
      tick();
      check("done", done, 1);
      check("done_busy", busy, 0);
      tick();
      check("done_pulse", done, 0);
      check("lba_hold", hps.mist_lba, v.lba);
    end
    check("done_count", 64'(done_cnt - d0), v.exp_ok ? 64'd1 : 64'd0);
    check("err_count", 64'(err_cnt - e0), v.exp_ok ? 64'd0 : 64'd1);
  endtask

  initial begin
    int d0, e0, cyc, rd_cnt, err_cyc;
    logic [7:0] exp;
    vec_t v;

    vecs[0] = '{1'b0, 1'b1, 2'd1, 32'h1234_5678, 4'b0000, 4'b0010, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 2'd0, 32'h0000_0005, 4'b0001, 4'b0000, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 2'd2, 32'h0000_0007, 4'b0000, 4'b0000, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 2'd0, 32'h0000_0009, 4'b0001, 4'b0000, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF, 4'b0000, 4'b0000, 1'b0};

    rstn = 1'b0;
    req_rd = 1'b0; req_wr = 1'b0; req_drv = '0; req_lba = '0;
    buf_addr = '0; buf_wdat = '0; buf_we = 1'b0;
    hps.mist_mounted = '0; hps.mist_imgsize = '0; hps.mist_ack = '0;
    hps.mist_buffaddr = '0; hps.mist_buffdout = '0; hps.mist_buffwr = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_req", {hps.mist_rd, hps.mist_wr}, 0);
    check("rst_lba", hps.mist_lba, 0);
    check("rst_mounted", mounted, 0);
    check("rst_rdat", {buf_rdat, hps.mist_buffdin}, 0);
    rstn = 1'b1;
    tick();

    mount(0, 64'h2000);
    check("mount0", mounted, 4'b0001);
    mount(1, 64'h1_0000_0000);
    check("mount1", mounted, 4'b0011);
    mount(3, 64'h0);
    check("mount3_empty", mounted, 4'b0011);

    // Buffer filled with addr[7:0] for the write entry
    for (int i = 0; i < 512; i++) begin
      buf_we = 1'b1; buf_addr = 9'(i); buf_wdat = 8'(i);
      tick();
    end
    buf_we = 1'b0;

    for (int k = 0; k < 5; k++) run_req(vecs[k]);

    // Buffer holds the last read sector: i ^ 0xA5
    for (int i = 0; i < 512; i++) begin
      buf_addr = 9'(i);
      sb.push_back(8'(i) ^ 8'hA5);
      tick();
      exp = sb.pop_front();
      check("buf_read", buf_rdat, exp);
    end
    buf_addr = 9'h1FF;
    tick();
    check("buf_1ff", buf_rdat, 8'h5A);

    // Timeout: no ack on a mounted drive, then a late ack is ignored
    d0 = done_cnt; rd_cnt = 0; err_cyc = 0;
    req_rd = 1'b1; req_drv = 2'd0; req_lba = 32'h40;
    for (int c = 1; c <= 40; c++) begin
      tick();
      req_rd = 1'b0;
      if (hps.mist_rd[0]) rd_cnt++;
      if (err) begin
        err_cyc = c;
        break;
      end
    end
    check("tmo_rd_cycles", rd_cnt, 15);
    check("tmo_err_cycle", err_cyc, 17);
    check("tmo_busy", busy, 0);
    hps.mist_ack = 4'b0001;
    tick(); tick(); tick();
    check("tmo_late_ack_req", hps.mist_rd, 0);
    check("tmo_late_ack_busy", busy, 0);
    hps.mist_ack = '0;
    tick(); tick();
    check("tmo_no_done", 64'(done_cnt - d0), 0);

    // Contention: buffer write and second request while busy are both dropped
    d0 = done_cnt;
    req_wr = 1'b1; req_drv = 2'd1; req_lba = 32'h0BAD;
    tick();
    req_wr = 1'b0;
    check("cont_wr", hps.mist_wr, 4'b0010);
    buf_we = 1'b1; buf_addr = 9'd0; buf_wdat = 8'h33;
    req_rd = 1'b1; req_drv = 2'd0; req_lba = 32'h0BEE;
    hps.mist_ack = 4'b0010;
    tick();
    buf_we = 1'b0; req_rd = 1'b0;
    check("cont_ign_rd", hps.mist_rd, 0);
    tick();
    hps.mist_ack = '0;
    wait_end("cont", 10, cyc);
    check("cont_done", done, 1);
    tick(); tick(); tick();
    check("cont_one_done", 64'(done_cnt - d0), 1);
    check("cont_no_rd", hps.mist_rd, 0);
    check("cont_lba", hps.mist_lba, 32'h0BAD);
    buf_addr = 9'd0;
    tick();
    check("cont_buf_kept", buf_rdat, 8'hA5);

    // Unmount during XFER aborts with err
    mount(2, 64'h100);
    check("mount2", mounted, 4'b0111);
    d0 = done_cnt; e0 = err_cnt;
    req_rd = 1'b1; req_drv = 2'd2; req_lba = 32'h77;
    tick();
    req_rd = 1'b0;
    check("abort_rd", hps.mist_rd, 4'b0100);
    hps.mist_ack = 4'b0100;
    tick(); tick();
    mount(2, 64'h0);
    check("abort_unmounted", mounted, 4'b0011);
    wait_end("abort", 5, cyc);
    check("abort_err", err, 1);
    hps.mist_ack = '0;
    tick(); tick();
    check("abort_err_count", 64'(err_cnt - e0), 1);
    check("abort_no_done", 64'(done_cnt - d0), 0);

    // Asynchronous reset mid-REQ
    req_rd = 1'b1; req_drv = 2'd0; req_lba = 32'h99;
    tick();
    req_rd = 1'b0;
    check("rstreq_rd", hps.mist_rd, 4'b0001);
    tick();
    #2 rstn = 1'b0;
    #1;
    check("rstmid_rd", hps.mist_rd, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_mounted", mounted, 0);
    check("rstmid_lba", hps.mist_lba, 0);
    tick();
    rstn = 1'b1;
    tick();
    check("rstmid_idle_rd", hps.mist_rd, 0);
    mount(0, 64'h2000);
    v = '{1'b1, 1'b0, 2'd0, 32'h1234, 4'b0001, 4'b0000, 1'b1};
    run_req(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "bench time limit");
  end

endmodule
